// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer pipeline register with flush and a saturating downstream-stall counter.
// in_ready is derived from registered state (gated by reset) so there is no combinational ready path.
module pipe_skid_reg #(
    parameter int unsigned       DATA_W     = 96,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter bit                FLUSH_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall_cnt_clr,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [15:0]       r_stall_cnt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_pop;
    logic w_main_ld_in;
    logic w_main_ld_skid;
    logic w_skid_ld;
    logic w_zero;

    assign w_in_ready  = rst_n && (r_state != SKID);
    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        w_zero         = 1'b0;
        if (flush) begin
            // Flush wins over any handshake: whatever is accepted this cycle is dropped.
            w_state_nxt = EMPTY;
            w_zero      = FLUSH_ZERO;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = FULL;
                        w_main_ld_in = 1'b1;
                    end
                end
                FULL: begin
                    if (w_accept && w_pop) begin
                        w_main_ld_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = SKID;
                        w_skid_ld   = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (w_pop) begin
                        w_state_nxt    = FULL;
                        w_main_ld_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else if (w_zero) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            if (w_main_ld_in) begin
                r_main <= in_data;
            end else if (w_main_ld_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_ld) begin
                r_skid <= in_data;
            end
        end
    end

    // Clear beats increment; flush deliberately leaves the counter alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, payload width (PC, Instr, PC+4 packed).
REQ-002 SHALL have parameter RESET_VAL, default 0, value driven on out_data after reset and flush.
REQ-003 SHALL have parameter FLUSH_ZERO, default 1; 1 = flush loads RESET_VAL into both entries, 0 = flush clears valid only.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream has payload.
REQ-007 SHALL have port in_ready  output  1  block can accept payload this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port flush  input  1  synchronous kill of all held payload (branch taken).
REQ-010 SHALL have port out_valid  output  1  out_data holds a live payload.
REQ-011 SHALL have port out_ready  input  1  downstream accepts payload this cycle.
REQ-012 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-013 SHALL have port stall_cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-014 SHALL have port stall_cnt  output  16  saturating count of downstream-stall cycles.

Function
REQ-015 SHALL hold two entries, main (drives out_data) and skid; state SHALL be one of EMPTY, FULL (main only), SKID (main and skid).
REQ-016 SHALL define accept = in_valid && in_ready and pop = out_valid && out_ready.
REQ-017 SHALL drive in_ready = 1 in EMPTY and FULL, 0 in SKID, derived from registered state only (no in_valid/out_ready combinational path).
REQ-018 SHALL drive out_valid = 1 in FULL and SKID, 0 in EMPTY.
REQ-019 EMPTY: accept -> FULL, main <= in_data; else stay.
REQ-020 FULL: accept && pop -> FULL, main <= in_data; accept && !pop -> SKID, skid <= in_data; !accept && pop -> EMPTY; else hold.
REQ-021 SKID: pop -> FULL, main <= skid; else hold.
REQ-022 SHALL have latency of one cycle: payload accepted at edge N appears on out_data with out_valid=1 after edge N when state was EMPTY.
REQ-023 SHALL preserve order; no payload SHALL be dropped or duplicated except by flush.
REQ-024 SHALL keep out_data stable while out_valid && !out_ready.
REQ-025 flush SHALL take priority over all transitions: next state EMPTY, payload accepted in the flush cycle discarded, entries loaded with RESET_VAL when FLUSH_ZERO=1.
REQ-026 SHALL sustain one payload per cycle when in_valid and out_ready are both held 1.
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, saturate at 16'hFFFF, and not wrap.
REQ-028 stall_cnt_clr SHALL set stall_cnt to 0, taking priority over increment in the same cycle; flush SHALL NOT affect stall_cnt.

Reset
REQ-029 rst_n low SHALL immediately, without clk, force state EMPTY, out_valid=0, out_data=RESET_VAL, skid=RESET_VAL, stall_cnt=0.
REQ-030 in_ready SHALL be 0 while rst_n is low and 1 from the first cycle after rst_n rises.
REQ-031 reset mid-operation (any state) SHALL discard all held payload; no stale payload SHALL appear after release.

Verification
REQ-032 Single pass: EMPTY, in_data=0x...0040 in_valid=1 one cycle, out_ready=1 -> out_valid=1, out_data=0x40 next cycle, EMPTY after.
REQ-033 Backpressure: out_ready=0, push A,B -> state SKID, in_ready=0, out_data=A; raise out_ready -> A then B out on consecutive cycles, then out_valid=0.
REQ-034 Streaming: in_valid=out_ready=1 for 10 cycles with values 1..10 -> out_data 1..10 on 10 consecutive cycles, in_ready constant 1.
REQ-035 Flush in SKID with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VAL (FLUSH_ZERO=1); flushed payloads never appear.
REQ-036 Stall counter: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; stall_cnt_clr with stall active -> 0.
REQ-037 Async reset: drop rst_n between clk edges while in FULL -> out_valid=0 and out_data=RESET_VAL before next edge; in_ready=1 first cycle after release.
